// File: rtl/lsu_mem_if.sv
// Load/store unit front end: one access per start pulse onto a word-wide req/ready bus.
// Optional MISALIGN_TRAP_EN macro turns misaligned half/word accesses into error completions.
module lsu_mem_if #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        r_dm,
  input  logic [1:0]        w_dm,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_we;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdat;
  logic [2:0]        r_rdm;
  logic [1:0]        r_lane;

  logic              w_rd;
  logic              w_wr;
  logic              w_mis;
  logic              w_go;
  logic              w_trap;
  logic              w_tmo;
  logic [3:0]        w_be;
  logic [31:0]       w_wdat;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld;

  assign w_rd = |r_dm[1:0];
  assign w_wr = |w_dm;

`ifdef MISALIGN_TRAP_EN
  logic [1:0] w_size;
  assign w_size = w_rd ? r_dm[1:0] : w_dm;
  assign w_mis  = ((w_size == 2'b10) && addr[0]) ||
                  ((w_size == 2'b11) && (addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_go   = start && (w_rd ^ w_wr) && !w_mis;
  assign w_trap = start && ((w_rd && w_wr) || ((w_rd ^ w_wr) && w_mis));
  assign w_tmo  = (TIMEOUT_CYC != 0) && (r_cnt == TMO_LAST);

  always_comb begin
    w_be   = 4'b1111;
    w_wdat = '0;
    unique case (1'b1)
      (w_dm == 2'b01): begin
        w_be   = 4'b0001 << addr[1:0];
        w_wdat = {4{wdata[7:0]}};
      end
      (w_dm == 2'b10): begin
        w_be   = addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{wdata[15:0]}};
      end
      (w_dm == 2'b11): begin
        w_wdat = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    unique case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ld   = mem_rdata;
    unique case (r_rdm[1:0])
      2'b01: w_ld = r_rdm[2] ? {24'b0, w_byte}
                             : {{24{w_byte[7]}}, w_byte};
      2'b10: w_ld = r_rdm[2] ? {16'b0, w_half}
                             : {{16{w_half[15]}}, w_half};
      default: w_ld = mem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_trap)    w_next = S_DONE;
        else if (w_go) w_next = S_BUS;
      end
      S_BUS:  if (mem_ready || w_tmo) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdat  <= '0;
      r_rdm   <= '0;
      r_lane  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_addr <= {addr[ADDR_W-1:2], 2'b00};
            r_be   <= w_be;
            r_wdat <= w_wdat;
            r_we   <= w_wr;
            r_rdm  <= r_dm;
            r_lane <= addr[1:0];
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end else if (w_trap) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_BUS: begin
          // ready wins over a timeout landing on the same cycle
          if (mem_ready) begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            if (!r_we) r_rdata <= w_ld;
          end else if (w_tmo) begin
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign mem_req   = (r_state == S_BUS);
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdat;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed scenarios plus random accesses
// checked against a behavioural lane/extension model.
module tb_lsu_mem_if;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  r_dm;
  logic [1:0]  w_dm;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_run  = 0;
  int n_fail = 0;

  lsu_mem_if #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr),
    .wdata(wdata), .r_dm(r_dm), .w_dm(w_dm), .busy(busy),
    .done(done), .rdata(rdata), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] m_be(input logic [1:0] wd,
                                      input logic [31:0] a);
    if (wd == 2'd1) return 4'(1 << (a % 4));
    if (wd == 2'd2) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] wd,
                                          input logic [31:0] d);
    if (wd == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
    if (wd == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] rd,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    bit zx;
    zx = rd[2];
    if (rd[1:0] == 2'd1) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!zx && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (rd[1:0] == 2'd2) begin
      v = (w >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
      if (!zx && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic bit m_both(input logic [2:0] rd,
                                input logic [1:0] wd);
    return (rd[1:0] != 0) && (wd != 0);
  endfunction

  function automatic bit m_mis(input logic [2:0] rd,
                               input logic [1:0] wd,
                               input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    int sz;
    sz = (rd[1:0] != 0) ? int'(rd[1:0]) : int'(wd);
    return (sz == 2 && (a % 2) != 0) || (sz == 3 && (a % 4) != 0);
`else
    return (rd[1:0] == 2'd3) && (wd == 2'd3) && (a == 32'h1);
`endif
  endfunction

  task automatic access(input logic [2:0] rd, input logic [1:0] wd,
                        input logic [31:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] word,
                        input bit poke);
    bit ld, both, mis;
    logic [31:0] erd;
    logic [37:0] ectl;
    logic [31:0] ewd;
    ld   = (rd[1:0] != 0);
    both = m_both(rd, wd);
    mis  = !both && m_mis(rd, wd, a);
    erd  = m_load(rd, a, word);
    ewd  = ld ? 32'h0 : m_wdata(wd, d);
    ectl = {1'b1, !ld, ld ? 4'hF : m_be(wd, a), a & 32'hFFFF_FFFC};
    start = 1'b1; r_dm = rd; w_dm = wd; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0; r_dm = '0; w_dm = '0;
    addr = $urandom; wdata = $urandom;
    if (both || mis) begin
      n_run++;
      if ({done, err, mem_req, busy} !== 4'b1101) begin
        n_fail++;
        $display("FAIL trap_ctl a=%h got %b exp 1101", a,
                 {done, err, mem_req, busy});
      end
      if (mis) begin
        n_run++;
        if (rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL trap_rdata got %h exp 0", rdata);
        end
      end
      @(negedge clk);
      n_run++;
      if ({done, busy, mem_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL trap_end got %b exp 000", {done, busy, mem_req});
      end
      return;
    end
    for (int k = 0; k <= dly; k++) begin
      n_run++;
      if ({mem_req, mem_we, mem_be, mem_addr, busy, done} !==
          {ectl, 2'b10}) begin
        n_fail++;
        $display("FAIL bus_ctl k=%0d got %h exp %h", k,
                 {mem_req, mem_we, mem_be, mem_addr, busy, done},
                 {ectl, 2'b10});
      end
      if (!ld) begin
        n_run++;
        if (mem_wdata !== ewd) begin
          n_fail++;
          $display("FAIL bus_wdata got %h exp %h", mem_wdata, ewd);
        end
      end
      mem_ready = (k == dly);
      mem_rdata = (k == dly) ? word : $urandom;
      if (poke && k == 1) begin
        start = 1'b1; w_dm = 2'b11;
      end
      @(negedge clk);
      start = 1'b0; w_dm = '0;
    end
    mem_ready = 1'b0;
    n_run++;
    if ({done, err, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL done_ctl got %b exp 100", {done, err, mem_req});
    end
    if (ld) begin
      n_run++;
      if (rdata !== erd) begin
        n_fail++;
        $display("FAIL load_data a=%h rd=%b got %h exp %h",
                 a, rd, rdata, erd);
      end
    end
    @(negedge clk);
    n_run++;
    if ({done, busy, mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL after_done got %b exp 000", {done, busy, mem_req});
    end
    if (ld) begin
      n_run++;
      if (rdata !== erd) begin
        n_fail++;
        $display("FAIL rdata_hold got %h exp %h", rdata, erd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; addr = '0; wdata = '0;
    r_dm = '0; w_dm = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({busy, done, err, mem_req, mem_we, mem_be} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b exp 0",
               {busy, done, err, mem_req, mem_we, mem_be});
    end
    n_run++;
    if ({rdata, mem_addr, mem_wdata} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 0",
               {rdata, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    access(3'b000, 2'b11, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    access(3'b000, 2'b01, 32'h23, 32'h0000_00A5, 1, 32'h0, 1'b0);
    access(3'b001, 2'b00, 32'h22, 32'h0, 0, 32'h0080_0000, 1'b0);
    access(3'b101, 2'b00, 32'h22, 32'h0, 2, 32'h0080_0000, 1'b0);
    access(3'b010, 2'b00, 32'h12, 32'h0, 3, 32'h8001_1234, 1'b1);
  endtask

  task automatic test_timeout();
    start = 1'b1; r_dm = 3'b011; addr = 32'h40;
    @(negedge clk);
    start = 1'b0; r_dm = '0;
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if ({mem_req, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL tmo_req k=%0d got %b exp 10", k, {mem_req, done});
      end
      @(negedge clk);
    end
    n_run++;
    if ({done, err, mem_req, rdata} !== {3'b110, 32'h0}) begin
      n_fail++;
      $display("FAIL tmo_done got %h exp %h",
               {done, err, mem_req, rdata}, {3'b110, 32'h0});
    end
    @(negedge clk);
    n_run++;
    if ({done, busy, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL tmo_end got %b exp 000", {done, busy, err});
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; r_dm = 3'b011; addr = 32'h20;
    @(negedge clk);
    start = 1'b0; r_dm = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_run++;
    if ({mem_req, done, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid got %b exp 000", {mem_req, done, busy});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      n_run++;
      if ({done, mem_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_nodone k=%0d got %b exp 00", k, {done, mem_req});
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_misalign_illegal();
    access(3'b011, 2'b00, 32'h13, 32'h0, 0, 32'h1357_9BDF, 1'b0);
    access(3'b001, 2'b01, 32'h30, 32'h55, 0, 32'h0, 1'b0);
    access(3'b010, 2'b10, 32'h31, 32'h55, 0, 32'h0, 1'b0);
  endtask

  task automatic test_noop();
    start = 1'b1; r_dm = 3'b100; w_dm = 2'b00; addr = 32'h44;
    @(negedge clk);
    start = 1'b0; r_dm = '0;
    n_run++;
    if ({busy, done, mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL noop got %b exp 000", {busy, done, mem_req});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] rd;
    logic [1:0] wd;
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 2 == 0) begin
        rd = {1'($urandom % 2), 2'(1 + $urandom % 3)};
        wd = 2'b00;
      end else begin
        rd = 3'b000;
        wd = 2'(1 + $urandom % 3);
      end
      access(rd, wd, $urandom, $urandom, int'($urandom % 4),
             $urandom, 1'($urandom % 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_misalign_illegal();
    test_noop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
